mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath. Sequences fetch, decode, execute, memory and write-back over several cycles.
- Drives all datapath selects, including the 2-bit register write-address select (rt / rd / $31) and the write enables for PC, IR, DM and RF.
- Sits between the IR opcode/funct fields and the shared ALU, memory and register-file datapath.
- Counts retired instructions for the testbench.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_decode.sv | 30 +++
 rtl/mc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
package mc_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // Exactly one field is set for any opcode/funct combination.
  typedef struct packed {
    logic rtype;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction class decode: opcode/funct to a one-hot class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  // Anything not recognised falls into the nop class.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == F_ADDU || funct == F_SUBU) cls.rtype = 1'b1;
        else if (funct == F_JR)                 cls.jr    = 1'b1;
        else                                    cls.nop   = 1'b1;
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with output decode and retire counter.
//
// state | meaning
// S_IF  | fetch: load IR, PC <= PC+4
// S_ID  | decode; j/jr/nop finish here
// S_EXE | ALU operation; beq resolves here
// S_MEM | data memory access (lw read, sw write)
// S_WB  | register file write; jal also loads the PC target
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic [1:0]       npc_sel,
  output logic             ext_op,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             dm_we,
  output logic             rf_we,
  output logic [1:0]       reg_dst,
  output logic             [1:0] wd_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [2:0]       state
);

  // The $31 write address is produced by the reg_dst mux; only sanity-check it.
  if (RA_IDX < 0 || RA_IDX > 31) begin : g_bad_ra_idx
    $error("mc_ctrl: RA_IDX must be a valid register index");
  end

  iclass_t          cls;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // Next-state selection by instruction class.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID: begin
        if (cls.j || cls.jr || cls.nop) state_d = S_IF;
        else if (cls.jal)               state_d = S_WB;
        else                            state_d = S_EXE;
      end
      S_EXE: begin
        if (cls.beq)              state_d = S_IF;
        else if (cls.lw || cls.sw) state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM: state_d = cls.sw ? S_IF : S_WB;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Output decode; everything is held at zero while reset is low so an
  // interrupted instruction cannot complete a write.
  always_comb begin
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    npc_sel = NPC_PC4;
    ext_op  = 1'b0;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    dm_we   = 1'b0;
    rf_we   = 1'b0;
    reg_dst = RD_RT;
    wd_sel  = WD_ALU;
    retire  = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        S_ID: begin
          if (cls.j) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
            retire  = 1'b1;
          end else if (cls.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_RS;
            retire  = 1'b1;
          end else if (cls.nop) begin
            retire  = 1'b1;
          end
        end
        S_EXE: begin
          if (cls.rtype) begin
            alu_op = (funct == F_SUBU) ? ALU_SUB : ALU_ADD;
          end else if (cls.ori) begin
            alu_src = 1'b1;
            alu_op  = ALU_OR;
          end else if (cls.lui) begin
            alu_src = 1'b1;
            alu_op  = ALU_LUI;
          end else if (cls.lw || cls.sw) begin
            ext_op  = 1'b1;
            alu_src = 1'b1;
          end else if (cls.beq) begin
            alu_op  = ALU_SUB;
            npc_sel = NPC_BR;
            pc_we   = zero;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          if (cls.sw) begin
            dm_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          retire = 1'b1;
          if (cls.rtype) begin
            reg_dst = RD_RD;
          end else if (cls.lw) begin
            wd_sel  = WD_DM;
          end else if (cls.jal) begin
            reg_dst = RD_RA;
            wd_sel  = WD_PC;
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
          end
        end
        default: ;
      endcase
    end
  end

  // Retire counter wraps naturally at the top of its range.
  always_comb begin
    retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IF;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle script model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic        pc_we, ir_we, ext_op, alu_src, dm_we, rf_we, retire;
  logic [1:0]  npc_sel, alu_op, reg_dst, wd_sel;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  mc_ctrl #(.RA_IDX(31), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .npc_sel    (npc_sel),
    .ext_op     (ext_op),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .dm_we      (dm_we),
    .rf_we      (rf_we),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] npc;
    logic       ext;
    logic       src;
    logic [1:0] aop;
    logic       dm_we;
    logic       rf_we;
    logic [1:0] rdst;
    logic [1:0] wds;
    logic       retire;
  } step_t;

  step_t       seq[$];
  step_t       exp_s;
  step_t       act_s;
  logic        exp_valid = 1'b0;
  logic [31:0] model_cnt = 32'd0;
  string       cur_name = "";
  int          checks = 0;
  int          errors = 0;

  assign act_s = {state, pc_we, ir_we, npc_sel, ext_op, alu_src, alu_op,
                  dm_we, rf_we, reg_dst, wd_sel, retire};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Cycle-by-cycle script of what one instruction must do, from the
  // instruction-class rules (IF, then class-specific steps).
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    step_t s;
    logic  is_r, is_jr;
    is_r  = (op == 6'h00) && (fn == 6'h21 || fn == 6'h23);
    is_jr = (op == 6'h00) && (fn == 6'h08);
    seq.delete();
    s = '0; s.st = 3'd0; s.pc_we = 1'b1; s.ir_we = 1'b1; seq.push_back(s);
    s = '0; s.st = 3'd1;
    if (op == 6'h02) begin
      s.pc_we = 1'b1; s.npc = 2'd2; s.retire = 1'b1; seq.push_back(s);
    end else if (is_jr) begin
      s.pc_we = 1'b1; s.npc = 2'd3; s.retire = 1'b1; seq.push_back(s);
    end else if (op == 6'h03) begin
      seq.push_back(s);
      s = '0; s.st = 3'd4; s.rf_we = 1'b1; s.rdst = 2'd2; s.wds = 2'd2;
      s.pc_we = 1'b1; s.npc = 2'd2; s.retire = 1'b1; seq.push_back(s);
    end else if (is_r || op == 6'h0D || op == 6'h0F || op == 6'h23 ||
                 op == 6'h2B || op == 6'h04) begin
      seq.push_back(s);
      s = '0; s.st = 3'd2;
      if (is_r) s.aop = (fn == 6'h23) ? 2'd1 : 2'd0;
      else if (op == 6'h0D) begin s.src = 1'b1; s.aop = 2'd2; end
      else if (op == 6'h0F) begin s.src = 1'b1; s.aop = 2'd3; end
      else if (op == 6'h04) begin s.aop = 2'd1; s.npc = 2'd1; s.pc_we = z; s.retire = 1'b1; end
      else begin s.ext = 1'b1; s.src = 1'b1; end
      seq.push_back(s);
      if (op == 6'h23 || op == 6'h2B) begin
        s = '0; s.st = 3'd3;
        if (op == 6'h2B) begin s.dm_we = 1'b1; s.retire = 1'b1; end
        seq.push_back(s);
      end
      if (op != 6'h04 && op != 6'h2B) begin
        s = '0; s.st = 3'd4; s.rf_we = 1'b1; s.retire = 1'b1;
        if (is_r) s.rdst = 2'd1;
        if (op == 6'h23) s.wds = 2'd1;
        seq.push_back(s);
      end
    end else begin
      s.retire = 1'b1; seq.push_back(s);
    end
  endtask

  // Compare process: outputs and count against the model every scripted cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      check({cur_name, " outputs"}, {14'd0, act_s}, {14'd0, exp_s});
      check({cur_name, " retire_cnt"}, retire_cnt, model_cnt);
    end
  end

  // Entered and left at 1 time unit after the posedge that starts S_IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int exp_lat, input string name, input int stop_after);
    int lat;
    int n;
    lat = 0;
    build(op, fn, z);
    n = (stop_after > 0) ? stop_after : seq.size();
    opcode = op;
    funct  = fn;
    for (int i = 0; i < n; i++) begin
      exp_s     = seq[i];
      cur_name  = $sformatf("%s step%0d", name, i);
      zero      = (seq[i].st == 3'd2) ? z : 1'($urandom);
      exp_valid = 1'b1;
      @(negedge clk);
      if (retire === 1'b1 && lat == 0) lat = i + 1;
      @(posedge clk);
      if (exp_s.retire) model_cnt = model_cnt + 32'd1;
      #1;
    end
    exp_valid = 1'b0;
    if (stop_after == 0)
      check({name, " latency"}, lat, (exp_lat == 0) ? seq.size() : exp_lat);
  endtask

  task automatic run_random(input int idx);
    int          k;
    logic [5:0]  op, fn;
    k  = $urandom_range(0, 10);
    fn = 6'($urandom);
    case (k)
      0: begin op = 6'h00; fn = 6'h21; end
      1: begin op = 6'h00; fn = 6'h23; end
      2: op = 6'h0D;
      3: op = 6'h0F;
      4: op = 6'h23;
      5: op = 6'h2B;
      6: op = 6'h04;
      7: op = 6'h02;
      8: op = 6'h03;
      9: begin op = 6'h00; fn = 6'h08; end
      default: begin op = 6'h00; fn = 6'h2A; end
    endcase
    run_instr(op, fn, 1'($urandom), 0, $sformatf("rand%0d op%0h", idx, op), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", {29'd0, state}, 32'd0);
    check("reset enables", {24'd0, pc_we, ir_we, dm_we, rf_we, retire, npc_sel, 1'b0},
          32'd0);
    check("reset selects", {28'd0, reg_dst, wd_sel}, 32'd0);
    check("reset count", retire_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(6'h00, 6'h21, 1'b0, 4, "addu", 0);
    check("count after addu", retire_cnt, 32'd1);
    run_instr(6'h23, 6'h15, 1'b0, 5, "lw", 0);
    run_instr(6'h04, 6'h00, 1'b1, 3, "beq_taken", 0);
    run_instr(6'h04, 6'h00, 1'b0, 3, "beq_not_taken", 0);
    run_instr(6'h03, 6'h3C, 1'b1, 3, "jal", 0);
    run_instr(6'h0D, 6'h07, 1'b0, 4, "ori", 0);
    run_instr(6'h00, 6'h23, 1'b1, 4, "subu", 0);
    run_instr(6'h2B, 6'h00, 1'b0, 4, "sw", 0);
    check("count before abort", retire_cnt, 32'd8);

    // Abort an sw in its S_MEM cycle: no DM write, back to fetch.
    run_instr(6'h2B, 6'h00, 1'b0, 0, "sw_abort", 3);
    reset = 1'b0;
    @(negedge clk);
    check("abort mem state", {29'd0, state}, 32'd3);
    check("abort mem writes", {29'd0, dm_we, rf_we, retire}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort reset state", {29'd0, state}, 32'd0);
    check("abort reset enables", {28'd0, dm_we, rf_we, pc_we, ir_we}, 32'd0);
    check("abort reset count", retire_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_cnt = 32'd0;

    run_instr(6'h02, 6'h11, 1'b0, 2, "j", 0);
    run_instr(6'h00, 6'h08, 1'b1, 2, "jr", 0);
    run_instr(6'h00, 6'h00, 1'b0, 2, "nop", 0);
    run_instr(6'h3F, 6'h21, 1'b1, 2, "op3f", 0);
    for (int i = 0; i < 6; i++) run_random(i);
    check("count after stream", retire_cnt, 32'd10);

    // Wrap: preload the counter during an S_IF (no retire) and retire a nop.
    opcode = 6'h00;
    funct  = 6'h00;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap preload", retire_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    release dut.retire_cnt_q;
    @(negedge clk);
    check("wrap retire pulse", {31'd0, retire}, 32'd1);
    check("wrap held value", retire_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("wrap to zero", retire_cnt, 32'd0);
    check("wrap back to fetch", {29'd0, state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
